comb_truth_table_sweeper: RTL and testbench

Sequencer and capture stage wrapped around a 4-input combinational boolean block (inputs a, b, c, d, output f). On a start request, it drives all 16 input combinations in ascending order and samples the block's f for each one. It assembles the results into a 16-bit truth table and hands the table to a downstream consumer over a valid/ready handshake. The block therefore sits both upstream of the combinational stage (it feeds it) and downstream of it (it consumes f).

---
 rtl/comb_truth_table_sweeper.sv | 98 +++++++++
 tb/tb_comb_truth_table_sweeper.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_truth_table_sweeper.sv
// Sweeps all 16 input combinations of a 4-input combinational block, captures f into a
// truth table with a running popcount, and offers the result over a valid/ready handshake.
module comb_truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        f,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        table_val,
  input  logic        table_rdy,
  output logic [15:0] tbl,
  output logic [4:0]  ones
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  ones_q, ones_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      settle_q <= 4'd0;
      tbl_q    <= 16'h0000;
      ones_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      tbl_q    <= tbl_d;
      ones_q   <= ones_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    tbl_d    = tbl_q;
    ones_d   = ones_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SWEEP;
          idx_d    = 4'd0;
          settle_d = 4'd0;
          tbl_d    = 16'h0000;
          ones_d   = 5'd0;
        end
      end
      SWEEP: begin
        if (settle_q == SETTLE_LAST) begin
          tbl_d[idx_q] = f;
          ones_d       = ones_q + {4'd0, f};
          settle_d     = 4'd0;
          // idx wraps 15 -> 0, so the driven combination is back to 0000 in DONE
          idx_d        = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = DONE;
          end
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      DONE: begin
        if (table_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // idx is zero outside SWEEP, so the combination outputs need no state gating
  assign a         = idx_q[3];
  assign b         = idx_q[2];
  assign c         = idx_q[1];
  assign d         = idx_q[0];
  assign busy      = (state_q == SWEEP);
  assign table_val = (state_q == DONE);
  assign tbl       = tbl_q;
  assign ones      = ones_q;

endmodule

// File: tb/tb_comb_truth_table_sweeper.sv
// Directed bench: one sweeper with SETTLE_CYCLES=1 and selectable f, one with
// SETTLE_CYCLES=3 driven by odd parity of its own combination outputs.
module tb_comb_truth_table_sweeper;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // DUT with S = 1
  logic        start1 = 1'b0, rdy1 = 1'b1, f1;
  logic        a1, b1, c1, d1, busy1, val1;
  logic [15:0] tbl1;
  logic [4:0]  ones1;
  logic [1:0]  fmode = 2'd0;

  // DUT with S = 3
  logic        start3 = 1'b0, rdy3 = 1'b1, f3;
  logic        a3, b3, c3, d3, busy3, val3;
  logic [15:0] tbl3;
  logic [4:0]  ones3;

  always_comb begin
    f1 = 1'b0;
    case (fmode)
      2'd0: f1 = 1'b0;
      2'd1: f1 = 1'b1;
      2'd2: f1 = a1 & b1;
      2'd3: f1 = a1 ^ b1 ^ c1 ^ d1;
      default: f1 = 1'b0;
    endcase
  end
  assign f3 = a3 ^ b3 ^ c3 ^ d3;

  comb_truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .f(f1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .table_val(val1),
    .table_rdy(rdy1), .tbl(tbl1), .ones(ones1)
  );

  comb_truth_table_sweeper #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .f(f3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .table_val(val3),
    .table_rdy(rdy3), .tbl(tbl3), .ones(ones3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start1 = 1'b0; start3 = 1'b0;
    tick(); tick();
    check_cnt++;
    if ({a1, b1, c1, d1, busy1, val1} !== 6'b0) $display("FAIL reset_ctl1 got=%b want=000000", {a1, b1, c1, d1, busy1, val1});
    else pass_cnt++;
    check_cnt++;
    if ({tbl1, ones1} !== 21'h0) $display("FAIL reset_tbl1 got tbl=%h ones=%0d want tbl=0000 ones=0", tbl1, ones1);
    else pass_cnt++;
    check_cnt++;
    if ({a3, b3, c3, d3, busy3, val3, tbl3, ones3} !== 27'h0) $display("FAIL reset_dut3 got=%h want=0", {a3, b3, c3, d3, busy3, val3, tbl3, ones3});
    else pass_cnt++;
    reset = 1'b1;
    tick(); tick(); tick();
    check_cnt++;
    if ({busy1, val1, a1, b1, c1, d1, tbl1, ones1} !== 27'h0) $display("FAIL idle_hold got=%h want=0", {busy1, val1, a1, b1, c1, d1, tbl1, ones1});
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_all_ones();
    int n;
    fmode = 2'd1; rdy1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_cnt++;
    if (!(busy1 === 1'b1 && {a1, b1, c1, d1} === 4'b0000)) $display("FAIL ones_first got busy=%b abcd=%b want busy=1 abcd=0000", busy1, {a1, b1, c1, d1});
    else pass_cnt++;
    n = 1;
    while (val1 !== 1'b1 && n < 200) begin tick(); n++; end
    check_cnt++;
    if (n != 17) $display("FAIL ones_latency got=%0d want=17", n);
    else pass_cnt++;
    check_cnt++;
    if (tbl1 !== 16'hFFFF || ones1 !== 5'd16 || busy1 !== 1'b0) $display("FAIL ones_table got tbl=%h ones=%0d busy=%b want tbl=ffff ones=16 busy=0", tbl1, ones1, busy1);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (val1 !== 1'b0 || busy1 !== 1'b0 || tbl1 !== 16'hFFFF) $display("FAIL ones_release got val=%b busy=%b tbl=%h want val=0 busy=0 tbl=ffff", val1, busy1, tbl1);
    else pass_cnt++;
    $display("test_all_ones done n=%0d tbl=%h", n, tbl1);
  endtask

  task automatic test_and();
    int n;
    fmode = 2'd2; rdy1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_cnt++;
      if ({a1, b1, c1, d1} !== 4'(i) || busy1 !== 1'b1 || val1 !== 1'b0) $display("FAIL and_step%0d got abcd=%b busy=%b val=%b want abcd=%b busy=1 val=0", i, {a1, b1, c1, d1}, busy1, val1, 4'(i));
      else pass_cnt++;
      tick();
    end
    check_cnt++;
    if (val1 !== 1'b1 || busy1 !== 1'b0 || {a1, b1, c1, d1} !== 4'b0000) $display("FAIL and_done got val=%b busy=%b abcd=%b want val=1 busy=0 abcd=0000", val1, busy1, {a1, b1, c1, d1});
    else pass_cnt++;
    check_cnt++;
    if (tbl1 !== 16'hF000 || ones1 !== 5'd4) $display("FAIL and_table got tbl=%h ones=%0d want tbl=f000 ones=4", tbl1, ones1);
    else pass_cnt++;
    n = 0;
    while (val1 === 1'b1 && n < 5) begin tick(); n++; end
    $display("test_and done tbl=%h", tbl1);
  endtask

  task automatic test_parity_s3();
    int n;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 48; i++) begin
      check_cnt++;
      if ({a3, b3, c3, d3} !== 4'(i / 3) || busy3 !== 1'b1) $display("FAIL s3_hold%0d got abcd=%b busy=%b want abcd=%b busy=1", i, {a3, b3, c3, d3}, busy3, 4'(i / 3));
      else pass_cnt++;
      tick();
    end
    n = 49;
    while (val3 !== 1'b1 && n < 300) begin tick(); n++; end
    check_cnt++;
    if (n != 49) $display("FAIL s3_latency got=%0d want=49", n);
    else pass_cnt++;
    check_cnt++;
    if (tbl3 !== 16'h6996 || ones3 !== 5'd8 || busy3 !== 1'b0) $display("FAIL s3_table got tbl=%h ones=%0d busy=%b want tbl=6996 ones=8 busy=0", tbl3, ones3, busy3);
    else pass_cnt++;
    tick();
    $display("test_parity_s3 done tbl=%h", tbl3);
  endtask

  task automatic test_backpressure();
    int n;
    fmode = 2'd3; rdy1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (val1 !== 1'b1 && n < 200) begin tick(); n++; end
    check_cnt++;
    if (n != 17 || tbl1 !== 16'h6996 || ones1 !== 5'd8) $display("FAIL bp_table got n=%0d tbl=%h ones=%0d want n=17 tbl=6996 ones=8", n, tbl1, ones1);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      start1 = ~start1;
      tick();
      check_cnt++;
      if (val1 !== 1'b1 || busy1 !== 1'b0 || tbl1 !== 16'h6996 || ones1 !== 5'd8) $display("FAIL bp_hold%0d got val=%b busy=%b tbl=%h ones=%0d want val=1 busy=0 tbl=6996 ones=8", i, val1, busy1, tbl1, ones1);
      else pass_cnt++;
    end
    start1 = 1'b0; rdy1 = 1'b1;
    tick();
    check_cnt++;
    if (val1 !== 1'b0 || busy1 !== 1'b0 || tbl1 !== 16'h6996) $display("FAIL bp_release got val=%b busy=%b tbl=%h want val=0 busy=0 tbl=6996", val1, busy1, tbl1);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (val1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL bp_idle got val=%b busy=%b want 0 0", val1, busy1);
    else pass_cnt++;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    int n;
    fmode = 2'd1; rdy1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_cnt++;
    if ({a1, b1, c1, d1} !== 4'd7 || busy1 !== 1'b1) $display("FAIL mid_pos got abcd=%b busy=%b want abcd=0111 busy=1", {a1, b1, c1, d1}, busy1);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    check_cnt++;
    if ({a1, b1, c1, d1, busy1, val1, tbl1, ones1} !== 27'h0) $display("FAIL mid_abort got=%h want=0", {a1, b1, c1, d1, busy1, val1, tbl1, ones1});
    else pass_cnt++;
    reset = 1'b1;
    tick();
    check_cnt++;
    if (busy1 !== 1'b0 || val1 !== 1'b0) $display("FAIL mid_idle got busy=%b val=%b want 0 0", busy1, val1);
    else pass_cnt++;
    fmode = 2'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n = 1;
    while (val1 !== 1'b1 && n < 200) begin tick(); n++; end
    check_cnt++;
    if (n != 17 || tbl1 !== 16'h0000 || ones1 !== 5'd0) $display("FAIL mid_resweep got n=%0d tbl=%h ones=%0d want n=17 tbl=0000 ones=0", n, tbl1, ones1);
    else pass_cnt++;
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    int rises[4];
    int nr;
    logic prev_busy;
    fmode = 2'd1; rdy1 = 1'b1;
    nr = 0;
    prev_busy = busy1;
    start1 = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (busy1 === 1'b1 && prev_busy !== 1'b1 && nr < 4) begin
        rises[nr] = cyc;
        nr++;
      end
      if (val1 === 1'b1) begin
        check_cnt++;
        if (tbl1 !== 16'hFFFF || ones1 !== 5'd16) $display("FAIL b2b_table got tbl=%h ones=%0d want tbl=ffff ones=16", tbl1, ones1);
        else pass_cnt++;
      end
      prev_busy = busy1;
    end
    start1 = 1'b0;
    check_cnt++;
    if (nr < 3) $display("FAIL b2b_count got=%0d want>=3", nr);
    else pass_cnt++;
    for (int i = 1; i < nr; i++) begin
      check_cnt++;
      if (rises[i] - rises[i-1] != 18) $display("FAIL b2b_period%0d got=%0d want=18", i, rises[i] - rises[i-1]);
      else pass_cnt++;
    end
    $display("test_back_to_back done sweeps=%0d", nr);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_and();
    test_parity_s3();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
